cook_timer_ctrl: RTL and testbench

COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

---
 rtl/cook_timer_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cook_timer_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cook_timer_ctrl.sv
// Kitchen countdown timer: MM:SS preset entry, start/pause countdown,
// and an alarm that clears itself after ALARM_TICKS seconds or on any button.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | show preset, wait for set/start
// SET   | show preset, increment buttons edit it
// RUN   | count down one second per tick_sec
// PAUSE | count frozen, ticks ignored
// ALARM | show 00:00, alarm high until timeout/button
module cook_timer_ctrl #(
  parameter int ALARM_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick_sec,
  input  logic       btn_start,
  input  logic       btn_set,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  input  logic       btn_clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       alarm,
  output logic       running,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  localparam int AW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ATICK_LAST = AW'(ALARM_TICKS - 1);

  logic [2:0]    cur, nxt;
  logic [15:0]   preset, preset_nxt;
  logic [15:0]   count, count_nxt;
  logic [15:0]   disp_nxt;
  logic [AW-1:0] atick, atick_nxt;
  logic          any_btn;

  // BCD increment of a 00-59 field, wrapping 59 -> 00
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r = (v[7:4] >= 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // One-second BCD decrement; only applied to a nonzero count
  function automatic logic [15:0] dec_mmss(input logic [15:0] c);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = c;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  assign any_btn = btn_start | btn_set | btn_inc_min | btn_inc_sec | btn_clear;

  always_comb begin
    nxt        = ST_IDLE;
    preset_nxt = preset;
    count_nxt  = count;
    atick_nxt  = atick;
    case (cur)
      ST_IDLE: begin
        nxt = ST_IDLE;
        if (btn_clear) begin
          nxt = ST_IDLE;
        end else if (btn_start && preset != 16'h0000) begin
          nxt       = ST_RUN;
          count_nxt = preset;
        end else if (btn_set) begin
          nxt = ST_SET;
        end
      end
      ST_SET: begin
        nxt = ST_SET;
        if (btn_clear || btn_start || btn_set) begin
          nxt = ST_IDLE;
        end else begin
          if (btn_inc_min) preset_nxt[15:8] = inc60(preset[15:8]);
          if (btn_inc_sec) preset_nxt[7:0]  = inc60(preset[7:0]);
        end
      end
      ST_RUN: begin
        nxt = ST_RUN;
        if (btn_clear) begin
          nxt = ST_IDLE;
        end else if (btn_start) begin
          nxt = ST_PAUSE;
        end else if (tick_sec) begin
          count_nxt = dec_mmss(count);
          if (count == 16'h0001) begin
            nxt       = ST_ALARM;
            atick_nxt = '0;
          end
        end
      end
      ST_PAUSE: begin
        nxt = ST_PAUSE;
        if (btn_clear) nxt = ST_IDLE;
        else if (btn_start) nxt = ST_RUN;
      end
      ST_ALARM: begin
        nxt = ST_ALARM;
        if (any_btn) begin
          nxt = ST_IDLE;
        end else if (tick_sec) begin
          if (atick == ATICK_LAST) nxt = ST_IDLE;
          else atick_nxt = atick + 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Display is derived from next-state values so it lines up with the state register
  always_comb begin
    disp_nxt = 16'h0000;
    case (nxt)
      ST_IDLE, ST_SET:  disp_nxt = preset_nxt;
      ST_RUN, ST_PAUSE: disp_nxt = count_nxt;
      default:          disp_nxt = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cur                        <= ST_IDLE;
      preset                     <= 16'h0000;
      count                      <= 16'h0000;
      atick                      <= '0;
      {min10, min1, sec10, sec1} <= 16'h0000;
      alarm                      <= 1'b0;
      running                    <= 1'b0;
      state                      <= ST_IDLE;
    end else begin
      cur                        <= nxt;
      preset                     <= preset_nxt;
      count                      <= count_nxt;
      atick                      <= atick_nxt;
      {min10, min1, sec10, sec1} <= disp_nxt;
      alarm                      <= (nxt == ST_ALARM);
      running                    <= (nxt == ST_RUN);
      state                      <= nxt;
    end
  end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl: stimulus pushes expected display/state
// into a queue, a monitor pops and compares each entry against the outputs.
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       tick_sec, btn_start, btn_set, btn_inc_min, btn_inc_sec, btn_clear;
  logic [3:0] min10, min1, sec10, sec1;
  logic       alarm, running;
  logic [2:0] state;

  cook_timer_ctrl #(.ALARM_TICKS(30)) dut (
    .clk(clk), .reset_p(reset_p), .tick_sec(tick_sec),
    .btn_start(btn_start), .btn_set(btn_set), .btn_inc_min(btn_inc_min),
    .btn_inc_sec(btn_inc_sec), .btn_clear(btn_clear),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .alarm(alarm), .running(running), .state(state)
  );

  always #4 clk = ~clk;

  localparam logic [5:0] B_TICK  = 6'b000001;
  localparam logic [5:0] B_ISEC  = 6'b000010;
  localparam logic [5:0] B_IMIN  = 6'b000100;
  localparam logic [5:0] B_SET   = 6'b001000;
  localparam logic [5:0] B_START = 6'b010000;
  localparam logic [5:0] B_CLEAR = 6'b100000;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [15:0] disp;
    logic        al;
    logic        rn;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic expect_o(input string nm, input logic [2:0] st, input logic [15:0] d);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.disp = d;
    e.al   = (st == 3'd4);
    e.rn   = (st == 3'd2);
    q.push_back(e);
  endtask

  task automatic pulse(input logic [5:0] v, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {btn_clear, btn_start, btn_set, btn_inc_min, btn_inc_sec, tick_sec} = v;
      @(negedge clk);
      {btn_clear, btn_start, btn_set, btn_inc_min, btn_inc_sec, tick_sec} = 6'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (state === e.st && {min10, min1, sec10, sec1} === e.disp &&
            alarm === e.al && running === e.rn)
          n_pass++;
        else
          $display("FAIL %s: got st=%0d disp=%h alarm=%b running=%b, want st=%0d disp=%h alarm=%b running=%b",
                   e.name, state, {min10, min1, sec10, sec1}, alarm, running,
                   e.st, e.disp, e.al, e.rn);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset_p = 1'b1;
    {btn_clear, btn_start, btn_set, btn_inc_min, btn_inc_sec, tick_sec} = 6'b0;
    repeat (2) @(negedge clk);
    expect_o("reset_state", 3'd0, 16'h0000);
    @(negedge clk);
    reset_p = 1'b0;

    // preset entry with seconds wrap
    pulse(B_SET);            expect_o("enter_set", 3'd1, 16'h0000);
    pulse(B_ISEC, 60);       expect_o("sec_wrap_60", 3'd1, 16'h0000);
    pulse(B_ISEC);           expect_o("sec_61", 3'd1, 16'h0001);
    pulse(B_IMIN, 2);        expect_o("min_x2", 3'd1, 16'h0201);
    pulse(B_SET);            expect_o("preset_0201_idle", 3'd0, 16'h0201);

    // reach 01:00 via minute wrap, leave SET with start (must not run)
    pulse(B_SET);
    pulse(B_ISEC, 59);
    pulse(B_IMIN, 59);       expect_o("preset_0100_set", 3'd1, 16'h0100);
    pulse(B_START);          expect_o("set_start_to_idle", 3'd0, 16'h0100);

    // countdown with borrow into alarm
    pulse(B_START);          expect_o("run_0100", 3'd2, 16'h0100);
    pulse(B_TICK);           expect_o("borrow_0059", 3'd2, 16'h0059);
    pulse(B_TICK, 58);       expect_o("count_0001", 3'd2, 16'h0001);
    pulse(B_TICK);           expect_o("alarm_entry", 3'd4, 16'h0000);
    pulse(B_TICK, 29);       expect_o("alarm_29_ticks", 3'd4, 16'h0000);
    pulse(B_TICK);           expect_o("alarm_timeout", 3'd0, 16'h0100);

    // pause behaviour
    pulse(B_SET);
    pulse(B_IMIN, 59);
    pulse(B_ISEC, 10);
    pulse(B_SET);            expect_o("preset_0010", 3'd0, 16'h0010);
    pulse(B_START);          expect_o("run_0010", 3'd2, 16'h0010);
    pulse(B_TICK, 3);        expect_o("count_0007", 3'd2, 16'h0007);
    pulse(B_START);          expect_o("pause_0007", 3'd3, 16'h0007);
    pulse(B_TICK, 5);        expect_o("pause_hold", 3'd3, 16'h0007);
    pulse(B_START);          expect_o("resume", 3'd2, 16'h0007);
    pulse(B_TICK);           expect_o("count_0006", 3'd2, 16'h0006);

    // tick collides with start: tick discarded
    pulse(B_TICK | B_START); expect_o("collision_pause", 3'd3, 16'h0006);
    pulse(B_CLEAR);          expect_o("clear_keeps_preset", 3'd0, 16'h0010);
    pulse(B_ISEC);           expect_o("inc_ignored_idle", 3'd0, 16'h0010);

    // second run, alarm ended by btn_set
    pulse(B_START);
    pulse(B_TICK, 9);        expect_o("rerun_0001", 3'd2, 16'h0001);
    pulse(B_TICK);           expect_o("rerun_alarm", 3'd4, 16'h0000);
    pulse(B_SET);            expect_o("alarm_btn_exit", 3'd0, 16'h0010);

    // zero preset: start ignored
    pulse(B_SET);
    pulse(B_ISEC, 50);       expect_o("preset_0000_set", 3'd1, 16'h0000);
    pulse(B_SET);
    pulse(B_START);          expect_o("zero_start_ignored", 3'd0, 16'h0000);

    // both increments together, then build 00:42 and reset mid-run
    pulse(B_SET);
    pulse(B_IMIN | B_ISEC);  expect_o("both_inc", 3'd1, 16'h0101);
    pulse(B_IMIN, 59);
    pulse(B_ISEC, 41);
    pulse(B_SET);            expect_o("preset_0042", 3'd0, 16'h0042);
    pulse(B_START);          expect_o("run_0042", 3'd2, 16'h0042);
    @(posedge clk);
    #2;
    reset_p = 1'b1;
    expect_o("async_reset_run", 3'd0, 16'h0000);
    @(negedge clk);
    #3;
    reset_p = 1'b0;
    pulse(6'b0);             expect_o("post_reset_preset", 3'd0, 16'h0000);

    repeat (2) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
